// File: rtl/mole_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mole_scheduler_pkg
// Shared definitions for the whack-a-mole game sequencer:
//   - FSM state encoding
//   - hole count and score width
//   - small helpers for the saturating score and the one-hot mole pattern
// -----------------------------------------------------------------------------
package mole_scheduler_pkg;

    localparam int NUM_HOLES = 4;
    localparam int SCORE_W   = 8;
    localparam int UP_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_SPAWN = 3'd2,
        ST_UP    = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Score sticks at its maximum instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [1:0] h);
        return NUM_HOLES'(1) << h;
    endfunction

endpackage

// File: rtl/mole_scheduler_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Advances on every clock; shared with the LED pattern logic.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, loads SEED
//   q    - current LFSR state
// -----------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Right-shifting Galois form: the bit shifted out folds back onto taps 16,14,13,11.
    always_comb begin
        q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
// Whack-a-mole game sequencer. Restarts the countdown timer on a start press,
// then lights one mole at a time in a pseudo-random hole, scores whacks and
// shortens the mole up-time as the remaining seconds fall.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - one-cycle start pulse (debounced button)
//   whack[3:0]    - one-cycle whack pulses, one per hole
//   seconds[4:0]  - remaining seconds from the countdown timer
//   game_over     - countdown timer expired
//   restart_game  - one-cycle pulse that restarts the countdown timer
//   moles[3:0]    - one-hot lit hole, or 0
//   score[7:0]    - saturating hit count for this game
//   hit, miss     - one-cycle result pulses
//   playing       - high while a game is in progress
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mole_scheduler
    import mole_scheduler_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 10000,
    parameter int unsigned GAP_TICKS    = 3,
    parameter int unsigned UP_MIN_TICKS = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] whack,
    input  logic [4:0]           seconds,
    input  logic                 game_over,
    output logic                 restart_game,
    output logic [NUM_HOLES-1:0] moles,
    output logic [SCORE_W-1:0]   score,
    output logic                 hit,
    output logic                 miss,
    output logic                 playing
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [UP_W-1:0]  GAP_LAST  = UP_W'(GAP_TICKS - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [UP_W-1:0]        tick_num_q, tick_num_d;
    logic [UP_W-1:0]        up_ticks_q, up_ticks_d;
    logic [1:0]             hole_q, hole_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   first_gap_q, first_gap_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic                   restart_q, restart_d;
    logic [NUM_HOLES-1:0]   moles_q, moles_d;
    logic                   playing_q, playing_d;

    logic [15:0]            lfsr;
    logic                   tick;
    logic [1:0]             spawn_hole;
    logic                   unused_bits;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign unused_bits = ^{lfsr[15:2], seconds[1:0]};

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        tick_num_d = tick ? tick_num_q + 1'b1 : tick_num_q;

        // The previous hole lives in hole_q; bump on a repeat so moles never land twice in a row.
        spawn_hole = lfsr[1:0];
        if (prev_valid_q && (spawn_hole == hole_q)) begin
            spawn_hole = spawn_hole + 2'd1;
        end

        state_d      = state_q;
        up_ticks_d   = up_ticks_q;
        hole_d       = hole_q;
        prev_valid_d = prev_valid_q;
        first_gap_d  = 1'b0;
        score_d      = score_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        restart_d    = 1'b0;
        moles_d      = '0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start && game_over) begin
                    restart_d    = 1'b1;
                    score_d      = '0;
                    prev_valid_d = 1'b0;
                    first_gap_d  = 1'b1;
                    tick_cnt_d   = '0;
                    tick_num_d   = '0;
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                // The timer still reports game_over for one cycle while it clears.
                if (game_over && !first_gap_q) begin
                    state_d = ST_OVER;
                end else if (tick && (tick_num_q == GAP_LAST)) begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else begin
                    hole_d       = spawn_hole;
                    prev_valid_d = 1'b1;
                    up_ticks_d   = UP_W'(UP_MIN_TICKS) + {3'b000, seconds[4:2]};
                    moles_d      = hole_onehot(spawn_hole);
                    tick_cnt_d   = '0;
                    tick_num_d   = '0;
                    state_d      = ST_UP;
                end
            end
            ST_UP: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (whack[hole_q]) begin
                    // A correct whack wins over any simultaneous wrong-hole bits.
                    score_d    = score_sat_inc(score_q);
                    hit_d      = 1'b1;
                    tick_cnt_d = '0;
                    tick_num_d = '0;
                    state_d    = ST_GAP;
                end else begin
                    miss_d = |whack;
                    if (tick && (tick_num_q == up_ticks_q - 1'b1)) begin
                        miss_d     = 1'b1;
                        tick_cnt_d = '0;
                        tick_num_d = '0;
                        state_d    = ST_GAP;
                    end else begin
                        moles_d = hole_onehot(hole_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        playing_d = (state_d == ST_GAP) || (state_d == ST_SPAWN) || (state_d == ST_UP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            tick_num_q   <= '0;
            up_ticks_q   <= '0;
            hole_q       <= '0;
            prev_valid_q <= 1'b0;
            first_gap_q  <= 1'b0;
            score_q      <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            restart_q    <= 1'b0;
            moles_q      <= '0;
            playing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_num_q   <= tick_num_d;
            up_ticks_q   <= up_ticks_d;
            hole_q       <= hole_d;
            prev_valid_q <= prev_valid_d;
            first_gap_q  <= first_gap_d;
            score_q      <= score_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            restart_q    <= restart_d;
            moles_q      <= moles_d;
            playing_q    <= playing_d;
        end
    end

    assign restart_game = restart_q;
    assign moles        = moles_q;
    assign score        = score_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign playing      = playing_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_scheduler
// Directed scenarios for the whack-a-mole sequencer with a cycle-level game
// model (phases with remaining-cycle budgets) checked against every output on
// every cycle, plus literal expectations at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_mole_scheduler;

    localparam int TC   = 4;
    localparam int GT   = 2;
    localparam int UPM  = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int P_IDLE  = 0;
    localparam int P_GAP   = 1;
    localparam int P_SPAWN = 2;
    localparam int P_UP    = 3;
    localparam int P_OVER  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] whack;
    logic [4:0] seconds;
    logic       game_over;
    logic       restart_game;
    logic [3:0] moles;
    logic [7:0] score;
    logic       hit;
    logic       miss;
    logic       playing;

    int total = 0;
    int bad   = 0;

    mole_scheduler #(
        .TICK_CYCLES  (TC),
        .GAP_TICKS    (GT),
        .UP_MIN_TICKS (UPM),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .whack        (whack),
        .seconds      (seconds),
        .game_over    (game_over),
        .restart_game (restart_game),
        .moles        (moles),
        .score        (score),
        .hit          (hit),
        .miss         (miss),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- game model ----------------
    int         m_phase;
    int         m_left;
    int         m_score;
    logic [1:0] m_prev;
    logic       m_pv;
    logic       m_first;
    logic       m_old_first;
    logic       m_hit;
    logic       m_miss;
    logic       m_restart;
    logic       m_valid = 1'b0;
    logic [15:0] m_lfsr;
    logic [15:0] m_cur;
    logic [1:0]  m_h;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic fb;
        fb = x[0];
        x  = x >> 1;
        if (fb) x = x ^ 16'hB400;
        return x;
    endfunction

    always @(posedge clk) begin
        m_hit     = 1'b0;
        m_miss    = 1'b0;
        m_restart = 1'b0;
        if (rst) begin
            m_phase = P_IDLE;
            m_score = 0;
            m_pv    = 1'b0;
            m_prev  = 2'd0;
            m_first = 1'b0;
            m_left  = 0;
            m_lfsr  = SEED;
            m_valid = 1'b1;
        end else begin
            m_cur       = m_lfsr;
            m_lfsr      = lfsr_next(m_lfsr);
            m_old_first = m_first;
            m_first     = 1'b0;
            case (m_phase)
                P_IDLE, P_OVER: begin
                    if (start && game_over) begin
                        m_restart = 1'b1;
                        m_score   = 0;
                        m_pv      = 1'b0;
                        m_first   = 1'b1;
                        m_left    = GT * TC;
                        m_phase   = P_GAP;
                    end
                end
                P_GAP: begin
                    if (game_over && !m_old_first) begin
                        m_phase = P_OVER;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_phase = P_SPAWN;
                    end
                end
                P_SPAWN: begin
                    if (game_over) begin
                        m_phase = P_OVER;
                    end else begin
                        m_h = m_cur[1:0];
                        if (m_pv && m_h == m_prev) m_h = m_h + 2'd1;
                        m_prev  = m_h;
                        m_pv    = 1'b1;
                        m_left  = (UPM + int'(seconds) / 4) * TC;
                        m_phase = P_UP;
                    end
                end
                default: begin
                    if (game_over) begin
                        m_phase = P_OVER;
                    end else if (whack[m_prev]) begin
                        m_hit   = 1'b1;
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_left  = GT * TC;
                        m_phase = P_GAP;
                    end else begin
                        if (whack != 4'd0) m_miss = 1'b1;
                        m_left--;
                        if (m_left == 0) begin
                            m_miss  = 1'b1;
                            m_left  = GT * TC;
                            m_phase = P_GAP;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [3:0] exp_moles;
        logic       exp_play;
        if (m_valid) begin
            exp_moles = (m_phase == P_UP) ? (4'd1 << m_prev) : 4'd0;
            exp_play  = (m_phase == P_GAP) || (m_phase == P_SPAWN) || (m_phase == P_UP);
            chk("cycle{restart,playing,hit,miss,moles,score}",
                {16'd0, restart_game, playing, hit, miss, moles, score},
                {16'd0, m_restart, exp_play, m_hit, m_miss, exp_moles, m_score[7:0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_lit(input string name);
        int n;
        n = 0;
        while (moles == 4'd0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (moles == 4'd0) begin
            bad++;
            $display("FAIL %s: no mole lit after %0d cycles, required within 30", name, n);
        end
    endtask

    int         zeros;
    int         lit;
    logic [3:0] held;

    initial begin
        rst = 1'b1; start = 1'b0; whack = 4'd0; seconds = 5'd29; game_over = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_moles", moles, 4'd0);
        chk("reset_score", score, 8'd0);
        chk("reset_playing", playing, 1'b0);
        chk("reset_restart", restart_game, 1'b0);

        // Start; game_over is still high during the first GAP cycle and must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_restart_hi", restart_game, 1'b1);
        chk("start_playing", playing, 1'b1);
        zeros = (moles == 4'd0) ? 1 : 0;
        @(negedge clk);
        game_over = 1'b0;
        chk("start_restart_lo", restart_game, 1'b0);
        if (moles == 4'd0) zeros++;
        while (moles == 4'd0 && zeros < 40) begin
            @(negedge clk);
            if (moles == 4'd0) zeros++;
        end
        chk("gap_plus_spawn_dark_cycles", zeros, 9);

        // Escaped mole: seconds=29 -> 3+7 = 10 ticks = 40 cycles lit.
        lit = 1;
        while (moles != 4'd0 && lit < 100) begin
            @(negedge clk);
            if (moles != 4'd0) lit++;
        end
        chk("up_cycles_s29", lit, 40);
        chk("escape_miss", miss, 1'b1);
        chk("escape_score", score, 8'd0);

        // Whack the lit hole on the 5th UP cycle.
        wait_lit("wait_mole_b");
        repeat (4) @(negedge clk);
        held  = moles;
        whack = moles;
        @(negedge clk);
        whack = 4'd0;
        chk("hit5_hit", hit, 1'b1);
        chk("hit5_score", score, 8'd1);
        chk("hit5_moles", moles, 4'd0);
        @(negedge clk);
        chk("hit5_hit_drop", hit, 1'b0);
        wait_lit("wait_mole_b2");
        chk("next_hole_differs", (moles == held) ? 1 : 0, 0);

        // Wrong hole, then the lit hole three cycles later.
        held  = moles;
        whack = {moles[2:0], moles[3]};
        @(negedge clk);
        whack = 4'd0;
        chk("wrong_miss", miss, 1'b1);
        chk("wrong_still_lit", moles, held);
        @(negedge clk);
        chk("wrong_miss_drop", miss, 1'b0);
        @(negedge clk);
        whack = moles;
        @(negedge clk);
        whack = 4'd0;
        chk("late_hit", hit, 1'b1);
        chk("late_no_miss", miss, 1'b0);
        chk("late_score", score, 8'd2);

        // Hit plus wrong-hole bits in the same cycle: hit only.
        wait_lit("wait_mole_c2");
        whack = 4'hF;
        @(negedge clk);
        whack = 4'd0;
        chk("all_hit", hit, 1'b1);
        chk("all_no_miss", miss, 1'b0);
        chk("all_score", score, 8'd3);

        // game_over together with a correct whack.
        wait_lit("wait_mole_d");
        game_over = 1'b1;
        whack     = moles;
        @(negedge clk);
        whack = 4'd0;
        chk("over_no_hit", hit, 1'b0);
        chk("over_moles", moles, 4'd0);
        chk("over_playing", playing, 1'b0);
        chk("over_score", score, 8'd3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_pulse", restart_game, 1'b1);
        chk("restart_score_clr", score, 8'd0);
        @(negedge clk);
        game_over = 1'b0;

        // 255 hits to reach saturation, then one more.
        for (int i = 0; i < 256; i++) begin
            wait_lit("wait_mole_sat");
            whack = moles;
            @(negedge clk);
            whack = 4'd0;
            if (i == 254) chk("score_255", score, 8'd255);
        end
        chk("sat_hit", hit, 1'b1);
        chk("sat_score", score, 8'd255);

        // Reset mid-game, then a start without game_over is ignored.
        wait_lit("wait_mole_rst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_moles", moles, 4'd0);
        chk("midrst_playing", playing, 1'b0);
        chk("midrst_restart", restart_game, 1'b0);
        chk("midrst_score", score, 8'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_no_gameover_restart", restart_game, 1'b0);
        chk("start_no_gameover_playing", playing, 1'b0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
